multicycle_alu: RTL
===================

Name: multicycle_alu

Overview:
- Parametrised, clocked successor to the single-cycle datapath ALU.
- Adds XOR/NOR/SRA/signed SLT and iterative MULT/MULTU/DIV/DIVU producing HI/LO results.
- Uses a start/busy/done handshake so the pipeline controller can stall while a multi-cycle operation runs.
- Sits in the EX stage; the HI/LO register file consumes result_hi/result_lo.

Parameters:
- WIDTH, 32, operand/result width; must be ≥ 4 and a power of two.
- SHW, $clog2(WIDTH), shift-amount width; derived, do not override.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- alu_op  in  4  operation code, sampled with start.
- operand1  in  WIDTH  rs value, sampled with start.
- operand2  in  WIDTH  rt value, sampled with start.
- shamt  in  SHW  shift amount, sampled with start.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when results become valid.
- result_lo  out  WIDTH  main result, product low half, or quotient.
- result_hi  out  WIDTH  product high half or remainder; 0 for single-cycle ops.
- zero  out  1  branch flag, valid with done.

Behaviour:
Reset:
- Asynchronous, active-low.
- State returns to IDLE; busy=0, done=0, result_lo=0, result_hi=0, zero=0, counter=0.
- Reset asserted mid-operation aborts the operation; no done is produced.

Op codes:
- 0 ADD, 1 SUB, 2 SLL, 3 SRL, 4 OR, 5 AND, 6 SLTU, 7 ADDNE, 8 XOR, 9 NOR, 10 SRA, 11 SLT, 12 MULT, 13 MULTU, 14 DIV, 15 DIVU.
- Shifts shift operand2 by shamt.
- SLT/SLTU produce 1 or 0, zero-extended to WIDTH.
- ADD/SUB wrap modulo 2^WIDTH; no overflow trap.

Zero flag:
- zero = (operand1 == operand2) for every op except ADDNE (7), where zero = (operand1 != operand2).
- ADDNE's result is operand1 + operand2.
- zero is latched together with the results.

State machine (IDLE, BUSY, DONE):
- IDLE & start & op<12 → DONE. Result is registered on the accept edge, so done is high in the cycle after start (latency 1).
- IDLE & start & op≥12 → BUSY. Operands are captured, counter=0, and signed ops take absolute values and record the result signs.
- BUSY: one iteration per cycle (shift-add multiply / restoring divide). After WIDTH iterations (counter==WIDTH-1) → DONE.
- BUSY sign fix-up: the final result sign is applied on the transition to DONE. done is therefore high WIDTH+1 cycles after start.
- DONE → IDLE unconditionally. done=1 only in DONE.
- Results hold their value until the next accepted start.
- start in BUSY or DONE is ignored (no queueing). start in IDLE is accepted even in the cycle right after DONE.
- Inputs other than start are don't-care outside the accept cycle.

Multiply:
- {result_hi, result_lo} = full 2·WIDTH-bit product, signed for MULT, unsigned for MULTU.

Divide:
- result_lo = quotient, truncated toward zero.
- result_hi = remainder, carrying the sign of the dividend.
- Divide by zero: quotient = all ones, remainder = operand1 (no exception). Same number of cycles as a normal divide.
- Signed overflow (DIV of most-negative by -1): quotient = most-negative, remainder = 0.

Decomposition:
- Package alu_pkg: alu_op_e enum with the 16 codes above, and state_e {IDLE, BUSY, DONE}.
- Sub-module muldiv_iter: iterative unsigned shift-add/restoring-divide engine (load, step, count, hi/lo outputs).
- Top level holds the FSM, the single-cycle combinational ops, sign handling and the output registers.

Test Plan:
Single-cycle ops (WIDTH=32):
- ADD 0x7FFFFFFF+1 → done next cycle, lo=0x80000000, hi=0, zero=0.
- SLT 0xFFFFFFFF vs 1 → lo=1.
- SLTU on the same operands → lo=0.
- SRA 0x80000000 by 4 → lo=0xF8000000.

Zero flag:
- ADDNE 5,5 → zero=0.
- SUB 5,5 → lo=0, zero=1.

Multiply:
- MULT -3×5 → done exactly 33 cycles after start, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU 0xFFFFFFFF×2 → hi=1, lo=0xFFFFFFFE.

Divide:
- DIV 7/-2 → lo=0xFFFFFFFD, hi=1.
- DIVU 10/0 → lo=0xFFFFFFFF, hi=0xA, done at 33 cycles.
- DIV 0x80000000/-1 → lo=0x80000000, hi=0.

Handshake:
- Pulse start with ADD in cycles 2–10 of an in-flight DIVU → ignored, busy stays 1, exactly one done.
- New start in the cycle after done → accepted.

Reset:
- Drop reset_n at cycle 10 of a MULT → busy=0, done=0, outputs 0 immediately.
- No done after reset release until a new start.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle EX-stage ALU: operation codes and FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SRL   = 4'd3,
    ALU_OR    = 4'd4,
    ALU_AND   = 4'd5,
    ALU_SLTU  = 4'd6,
    ALU_ADDNE = 4'd7,
    ALU_XOR   = 4'd8,
    ALU_NOR   = 4'd9,
    ALU_SRA   = 4'd10,
    ALU_SLT   = 4'd11,
    ALU_MULT  = 4'd12,
    ALU_MULTU = 4'd13,
    ALU_DIV   = 4'd14,
    ALU_DIVU  = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Unsigned iterative engine: shift-add multiply or restoring divide, one bit per step.
// hiNext_o/loNext_o expose the value the current step will produce.
module muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             isDiv_i,
  input  logic [WIDTH-1:0] opA_i,
  input  logic [WIDTH-1:0] opB_i,
  output logic [WIDTH-1:0] hiNext_o,
  output logic [WIDTH-1:0] loNext_o,
  output logic             last_o
);

  logic [WIDTH-1:0] hi_q, lo_q, divisor_q;
  logic             div_q;
  logic [SHW-1:0]   count_q;
  logic [WIDTH:0]   sum, shifted, diff;

  // A zero divisor never fails the trial subtract, giving an all-ones
  // quotient and the dividend as remainder without special casing.
  always_comb begin
    sum      = {1'b0, hi_q} + {1'b0, divisor_q};
    shifted  = {hi_q, lo_q[WIDTH-1]};
    diff     = shifted - {1'b0, divisor_q};
    hiNext_o = hi_q;
    loNext_o = lo_q;
    if (div_q) begin
      if (!diff[WIDTH]) begin
        hiNext_o = diff[WIDTH-1:0];
        loNext_o = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hiNext_o = shifted[WIDTH-1:0];
        loNext_o = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else if (lo_q[0]) begin
      {hiNext_o, loNext_o} = {sum, lo_q[WIDTH-1:1]};
    end else begin
      {hiNext_o, loNext_o} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q      <= '0;
      lo_q      <= '0;
      divisor_q <= '0;
      div_q     <= 1'b0;
      count_q   <= '0;
    end else if (load_i) begin
      hi_q      <= '0;
      lo_q      <= opA_i;
      divisor_q <= opB_i;
      div_q     <= isDiv_i;
      count_q   <= '0;
    end else if (step_i) begin
      hi_q    <= hiNext_o;
      lo_q    <= loNext_o;
      count_q <= count_q + 1'b1;
    end
  end

  assign last_o = (count_q == SHW'(WIDTH - 1));

endmodule

// File: rtl/multicycle_alu.sv
// EX-stage ALU: single-cycle ops complete in one cycle, MULT/DIV variants iterate
// WIDTH cycles behind a start/busy/done handshake and return HI/LO results.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   lo_q, lo_d, hi_q, hi_d;
  logic               zero_q, zero_d;
  logic               zeroPend_q, isDiv_q, loNeg_q, remNeg_q;

  alu_op_e            op;
  logic               isMulti, isSigned, isDiv, zeroNow, signDiffer;
  logic [WIDTH-1:0]   simpleLo, absA, absB;
  logic               engLoad, engStep, engLast;
  logic [WIDTH-1:0]   engHi, engLo, fixHi, fixLo;
  logic [2*WIDTH-1:0] prod, prodFix;

  assign op         = alu_op_e'(alu_op);
  assign isMulti    = alu_op[3] & alu_op[2];
  assign isSigned   = ~alu_op[0];
  assign isDiv      = alu_op[1];
  assign zeroNow    = (op == ALU_ADDNE) ? (operand1 != operand2) : (operand1 == operand2);
  assign signDiffer = operand1[WIDTH-1] ^ operand2[WIDTH-1];
  assign absA       = (isSigned && operand1[WIDTH-1]) ? -operand1 : operand1;
  assign absB       = (isSigned && operand2[WIDTH-1]) ? -operand2 : operand2;

  always_comb begin
    simpleLo = '0;
    case (op)
      ALU_ADD, ALU_ADDNE: simpleLo = operand1 + operand2;
      ALU_SUB:            simpleLo = operand1 - operand2;
      ALU_SLL:            simpleLo = operand2 << shamt;
      ALU_SRL:            simpleLo = operand2 >> shamt;
      ALU_OR:             simpleLo = operand1 | operand2;
      ALU_AND:            simpleLo = operand1 & operand2;
      ALU_SLTU:           simpleLo = {{(WIDTH-1){1'b0}}, operand1 < operand2};
      ALU_XOR:            simpleLo = operand1 ^ operand2;
      ALU_NOR:            simpleLo = ~(operand1 | operand2);
      ALU_SRA:            simpleLo = $unsigned($signed(operand2) >>> shamt);
      ALU_SLT:            simpleLo = {{(WIDTH-1){1'b0}}, $signed(operand1) < $signed(operand2)};
      default:            simpleLo = '0;
    endcase
  end

  muldiv_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_engine (
    .clk      (clk),
    .reset_n  (reset_n),
    .load_i   (engLoad),
    .step_i   (engStep),
    .isDiv_i  (isDiv),
    .opA_i    (absA),
    .opB_i    (absB),
    .hiNext_o (engHi),
    .loNext_o (engLo),
    .last_o   (engLast)
  );

  // Quotient stays all ones on divide-by-zero, so its negation is suppressed there.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      zeroPend_q <= 1'b0;
      isDiv_q    <= 1'b0;
      loNeg_q    <= 1'b0;
      remNeg_q   <= 1'b0;
    end else if (engLoad) begin
      zeroPend_q <= zeroNow;
      isDiv_q    <= isDiv;
      loNeg_q    <= isSigned & signDiffer & (~isDiv | (operand2 != '0));
      remNeg_q   <= isSigned & operand1[WIDTH-1];
    end
  end

  always_comb begin
    prod    = {engHi, engLo};
    prodFix = loNeg_q ? -prod : prod;
    if (isDiv_q) begin
      fixLo = loNeg_q ? -engLo : engLo;
      fixHi = remNeg_q ? -engHi : engHi;
    end else begin
      {fixHi, fixLo} = prodFix;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    zero_d  = zero_q;
    engLoad = 1'b0;
    engStep = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = isMulti ? BUSY : DONE;
          if (isMulti) begin
            engLoad = 1'b1;
          end else begin
            lo_d   = simpleLo;
            hi_d   = '0;
            zero_d = zeroNow;
          end
        end
      end
      BUSY: begin
        engStep = 1'b1;
        if (engLast) begin
          state_d = DONE;
          lo_d    = fixLo;
          hi_d    = fixHi;
          zero_d  = zeroPend_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign result_lo = lo_q;
  assign result_hi = hi_q;
  assign zero      = zero_q;

endmodule
